// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the bridge state encoding.
package wb_pkg;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } bridge_state_e;
endpackage

// File: rtl/wb_txn_fifo.sv
// Small FIFO of in-flight transfer tags; head is valid combinationally, registered pointers.
// Push and pop in the same cycle are both honoured, even when full; flush empties it in one cycle.
module wb_txn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign rd_en   = pop_i & ~empty_o;
  // A push popped in the same cycle into an empty FIFO bypasses storage entirely.
  assign wr_en   = push_i & (~full_o | pop_i) & ~(empty_o & pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/wb_data_bridge.sv
// Pipelined Wishbone master for the core data port: zero-latency request accept, 1-cycle registered response.
// Core is stalled when MAX_OUT transfers are outstanding, the slave stalls, or during the one-cycle abort.
module wb_data_bridge
  import wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                data_req_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [WB_DAT_W-1:0] data_wdata_i,
  input  logic [WB_SEL_W-1:0] data_wmask_i,
  input  logic                data_wen_i,
  output logic                data_stall_o,
  output logic [WB_DAT_W-1:0] data_rdata_o,
  output logic                data_rvalid_o,
  output logic                data_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [WB_DAT_W-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d, err_q, err_d;
  logic                full, accept, resp, timeout;
  logic                fifo_full, fifo_empty, head_is_read, cpl_is_read;

  // FIFO occupancy always equals cnt; either saturating blocks new requests.
  assign full         = (cnt_q == CNT_W'(MAX_OUT)) | fifo_full;
  assign wb_stb_o     = reset_i & data_req_i & ~full & (state_q != ABORT);
  assign wb_cyc_o     = wb_stb_o | (reset_i & (cnt_q != '0) & (state_q != ABORT));
  assign wb_we_o      = ~data_wen_i;
  assign wb_adr_o     = data_addr_i;
  assign wb_dat_o     = data_wdata_i;
  assign wb_sel_o     = data_wmask_i;
  assign accept       = wb_stb_o & ~wb_stall_i;
  assign data_stall_o = data_req_i & ~accept;
  assign resp         = (wb_ack_i | wb_err_i) & ((cnt_q != '0) | accept);
  assign cpl_is_read  = fifo_empty ? data_wen_i : head_is_read;
  assign timeout      = (TIMEOUT > 0) && (state_q == BUSY) && !(accept | wb_ack_i | wb_err_i)
                        && (wdog_q == WD_W'(TIMEOUT - 1));

  assign data_rdata_o  = rdata_q;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;

  wb_txn_fifo #(.DEPTH(MAX_OUT), .WIDTH(1)) u_txn_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (accept),
    .push_dat_i (data_wen_i),
    .pop_i      (resp),
    .flush_i    (timeout),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_is_read)
  );

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(resp);
    wdog_d   = wdog_q + 1'b1;
    state_d  = (cnt_d != '0) ? BUSY : IDLE;
    rvalid_d = resp & ~wb_err_i & cpl_is_read;
    err_d    = resp & wb_err_i;
    rdata_d  = rvalid_d ? wb_dat_i : rdata_q;
    if (accept | wb_ack_i | wb_err_i | (state_q != BUSY)) wdog_d = '0;
    if (timeout) begin
      cnt_d   = '0;
      wdog_d  = '0;
      state_d = ABORT;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wdog_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_data_bridge.sv
// Scoreboard bench for wb_data_bridge: scripted Wishbone slave, reference model feeding an expected-response queue.
module tb_wb_data_bridge;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic        is_err;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, req, wen, s_stall, s_ack, s_err;
  logic [31:0] addr, wdata, s_dat;
  logic [3:0]  wmask;
  logic        data_stall, rvalid, derr, cyc, stb, we;
  logic [31:0] rdata, adr, dat_o;
  logic [3:0]  sel;

  int   vectors = 0;
  int   miscompares = 0;
  int   n_rv = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic m_types[$];
  int   m_cnt = 0;
  int   m_wd = 0;
  bit   m_abort = 1'b0;
  bit   m_acc = 1'b0;

  wb_data_bridge #(.ADDR_W(32), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .data_req_i(req), .data_addr_i(addr), .data_wdata_i(wdata), .data_wmask_i(wmask),
    .data_wen_i(wen), .data_stall_o(data_stall), .data_rdata_o(rdata),
    .data_rvalid_o(rvalid), .data_err_o(derr),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
    .wb_sel_o(sel), .wb_stall_i(s_stall), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_dat_i(s_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, bench did not finish");
    $fatal(1);
  end

  // Every completion pulse from the DUT must match the oldest expectation, in order.
  always @(negedge clk) begin
    if (rvalid === 1'b1 || derr === 1'b1) begin
      if (rvalid === 1'b1) n_rv++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected got rvalid=%b err=%b rdata=%h, no response expected", rvalid, derr, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (derr !== mon_e.is_err || rvalid !== !mon_e.is_err || (!mon_e.is_err && rdata !== mon_e.dat)) begin
          miscompares++;
          $display("FAIL sb_response got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                   rvalid, derr, rdata, !mon_e.is_err, mon_e.is_err, mon_e.dat);
        end
      end
    end
  end

  task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [3:0] m);
    req = r; wen = w; addr = a; wdata = ~a; wmask = m;
  endtask

  task automatic set_slv(input logic st, input logic ak, input logic er, input logic [31:0] d);
    s_stall = st; s_ack = ak; s_err = er; s_dat = d;
  endtask

  // Advance one clock: update the reference model from the inputs held across the edge.
  task automatic tick();
    logic stb_m, rsp, is_rd;
    int   cnt0;
    exp_t e;
    cnt0  = m_cnt;
    stb_m = rst_n && req && (m_cnt != MAX_OUT) && !m_abort;
    m_acc = stb_m && !s_stall;
    rsp   = rst_n && (s_ack || s_err) && (m_cnt != 0 || m_acc);
    if (!rst_n) begin
      m_cnt = 0; m_wd = 0; m_abort = 1'b0; m_types.delete();
    end else if (m_abort) begin
      m_abort = 1'b0;
    end else begin
      if (m_acc) m_types.push_back(wen);
      if (rsp) begin
        is_rd = m_types.pop_front();
        if (s_err) begin e.is_err = 1'b1; e.dat = '0; exp_q.push_back(e); end
        else if (is_rd) begin e.is_err = 1'b0; e.dat = s_dat; exp_q.push_back(e); end
      end
      m_cnt = m_cnt + int'(m_acc) - int'(rsp);
      if (m_acc || s_ack || s_err || cnt0 == 0) m_wd = 0;
      else if (m_wd == TIMEOUT - 1) begin
        e.is_err = 1'b1; e.dat = '0; exp_q.push_back(e);
        m_cnt = 0; m_types.delete(); m_abort = 1'b1; m_wd = 0;
      end else m_wd++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(1'b1, 1'b1, 32'h40, 4'hF);
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    vectors++; if (stb !== 1'b0) begin miscompares++; $display("FAIL rst_stb got %b want 0", stb); end
    vectors++; if (cyc !== 1'b0) begin miscompares++; $display("FAIL rst_cyc got %b want 0", cyc); end
    tick(); tick();
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata); end
    vectors++; if (rvalid !== 1'b0 || derr !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got rvalid=%b err=%b want 0 0", rvalid, derr); end
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    rst_n = 1'b1;
    #1;
    vectors++; if (cyc !== 1'b0 || data_stall !== 1'b0) begin miscompares++; $display("FAIL rst_idle got cyc=%b stall=%b want 0 0", cyc, data_stall); end
    tick();
  endtask

  task automatic test_single_load();
    set_req(1'b1, 1'b1, 32'h100, 4'hF);
    #1;
    vectors++; if (stb !== 1'b1 || cyc !== 1'b1 || data_stall !== 1'b0) begin miscompares++; $display("FAIL single_issue got stb=%b cyc=%b stall=%b want 1 1 0", stb, cyc, data_stall); end
    vectors++; if (adr !== 32'h100 || we !== 1'b0) begin miscompares++; $display("FAIL single_addr got adr=%h we=%b want 00000100 0", adr, we); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    #1;
    vectors++; if (cyc !== 1'b1 || stb !== 1'b0) begin miscompares++; $display("FAIL single_hold got cyc=%b stb=%b want 1 0", cyc, stb); end
    tick();
    set_slv(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_resp got rvalid=%b rdata=%h want 1 deadbeef", rvalid, rdata); end
    vectors++; if (cyc !== 1'b0) begin miscompares++; $display("FAIL single_cyc_drop got %b want 0", cyc); end
    tick();
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL single_pulse_len got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_pipelined();
    int   issued = 0, acked = 0, dut_stalls = 0, rv0;
    logic ak, exp_st;
    rv0 = n_rv;
    for (int c = 0; c < 40 && acked < 6; c++) begin
      set_req(issued < 6, 1'b1, 32'h200 + 32'(issued * 4), 4'hF);
      ak = (c >= 5) && (acked < issued);
      set_slv(1'b0, ak, 1'b0, 32'hA000_0000 + 32'(acked));
      #1;
      exp_st = (issued < 6) && (m_cnt == MAX_OUT);
      vectors++; if (data_stall !== exp_st) begin miscompares++; $display("FAIL pipe_stall cycle %0d got %b want %b", c, data_stall, exp_st); end
      if (issued < 6 && data_stall === 1'b1) dut_stalls++;
      tick();
      if (m_acc) issued++;
      if (ak) acked++;
    end
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if (dut_stalls !== 2) begin miscompares++; $display("FAIL pipe_stall_cycles got %0d want 2", dut_stalls); end
    vectors++; if (n_rv - rv0 !== 6) begin miscompares++; $display("FAIL pipe_rvalid_count got %0d want 6", n_rv - rv0); end
  endtask

  task automatic test_mixed();
    int rv0;
    rv0 = n_rv;
    set_req(1'b1, 1'b0, 32'h300, 4'b0011);
    #1;
    vectors++; if (we !== 1'b1 || sel !== 4'b0011 || dat_o !== ~32'h300) begin miscompares++; $display("FAIL mixed_store0 got we=%b sel=%b dat=%h want 1 0011 %h", we, sel, dat_o, ~32'h300); end
    tick();
    set_req(1'b1, 1'b1, 32'h304, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'h55);
    #1;
    vectors++; if (we !== 1'b0 || data_stall !== 1'b0) begin miscompares++; $display("FAIL mixed_load got we=%b stall=%b want 0 0", we, data_stall); end
    tick();
    set_req(1'b1, 1'b0, 32'h308, 4'b1100);
    #1;
    vectors++; if (we !== 1'b1 || sel !== 4'b1100) begin miscompares++; $display("FAIL mixed_store2 got we=%b sel=%b want 1 1100", we, sel); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("FAIL mixed_store_ack_pulse got rvalid=%b want 0", rvalid); end
    tick();
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'h55) begin miscompares++; $display("FAIL mixed_load_pos got rvalid=%b rdata=%h want 1 00000055", rvalid, rdata); end
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    tick();
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if (n_rv - rv0 !== 1) begin miscompares++; $display("FAIL mixed_rvalid_count got %0d want 1", n_rv - rv0); end
  endtask

  task automatic test_simul_accept_ack();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 32'h400 + 32'(i * 4), 4'hF);
      tick();
    end
    set_req(1'b1, 1'b1, 32'h40C, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'hB0);
    #1;
    vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL simul_cnt3 got stall=%b want 0", data_stall); end
    tick();
    set_req(1'b1, 1'b1, 32'h410, 4'hF);
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL simul_cnt_held got stall=%b want 0", data_stall); end
    tick();
    set_req(1'b1, 1'b1, 32'h414, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'hB1);
    #1;
    vectors++; if (data_stall !== 1'b1 || stb !== 1'b0) begin miscompares++; $display("FAIL simul_full_ack got stall=%b stb=%b want 1 0", data_stall, stb); end
    tick();
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL simul_next_accept got stall=%b want 0", data_stall); end
    tick();
    set_req(1'b1, 1'b1, 32'h418, 4'hF);
    #1;
    vectors++; if (data_stall !== 1'b1) begin miscompares++; $display("FAIL simul_full_again got stall=%b want 1", data_stall); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      set_slv(1'b0, 1'b1, 1'b0, 32'hB2 + 32'(i));
      tick();
    end
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if (cyc !== 1'b0) begin miscompares++; $display("FAIL simul_drained got cyc=%b want 0", cyc); end
  endtask

  task automatic test_error();
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 32'h480 + 32'(i * 4), 4'hF);
      tick();
    end
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'hC1);
    tick();
    set_slv(1'b0, 1'b0, 1'b1, 32'hC2);
    tick();
    vectors++; if (derr !== 1'b1 || rvalid !== 1'b0) begin miscompares++; $display("FAIL err_pulse got err=%b rvalid=%b want 1 0", derr, rvalid); end
    set_slv(1'b0, 1'b1, 1'b0, 32'hC3);
    tick();
    vectors++; if (rvalid !== 1'b1 || derr !== 1'b0 || rdata !== 32'hC3) begin miscompares++; $display("FAIL err_after got rvalid=%b err=%b rdata=%h want 1 0 000000c3", rvalid, derr, rdata); end
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    int seen = 0;
    set_req(1'b1, 1'b1, 32'h500, 4'hF);
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (derr === 1'b1) begin seen = i; break; end
    end
    vectors++; if (seen !== TIMEOUT) begin miscompares++; $display("FAIL tmo_latency got err after %0d cycles want %0d", seen, TIMEOUT); end
    set_req(1'b1, 1'b1, 32'h504, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'hEE);
    #1;
    vectors++; if (cyc !== 1'b0 || stb !== 1'b0 || data_stall !== 1'b1) begin miscompares++; $display("FAIL tmo_abort got cyc=%b stb=%b stall=%b want 0 0 1", cyc, stb, data_stall); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    #1;
    vectors++; if (cyc !== 1'b0) begin miscompares++; $display("FAIL tmo_cnt_zero got cyc=%b want 0", cyc); end
    tick();
    vectors++; if (rvalid !== 1'b0 || derr !== 1'b0) begin miscompares++; $display("FAIL tmo_late_ack got rvalid=%b err=%b want 0 0", rvalid, derr); end
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 32'h508, 4'hF);
    #1;
    vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL tmo_recover got stall=%b want 0", data_stall); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'hC0FFEE);
    tick();
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, 1'b1, 32'h600 + 32'(i * 4), 4'hF);
      tick();
    end
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    rst_n = 1'b0;
    #1;
    vectors++; if (cyc !== 1'b0 || stb !== 1'b0) begin miscompares++; $display("FAIL rmid_cyc got cyc=%b stb=%b want 0 0", cyc, stb); end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (rdata !== 32'h0 || rvalid !== 1'b0 || derr !== 1'b0 || cyc !== 1'b0) begin miscompares++; $display("FAIL rmid_outputs got rdata=%h rvalid=%b err=%b cyc=%b want 0 0 0 0", rdata, rvalid, derr, cyc); end
    set_slv(1'b0, 1'b1, 1'b0, 32'hBAD);
    tick();
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 32'h610, 4'hF);
    #1;
    vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL rmid_accept got stall=%b want 0", data_stall); end
    tick();
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    set_slv(1'b0, 1'b1, 1'b0, 32'h12345678);
    tick();
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'h12345678) begin miscompares++; $display("FAIL rmid_load got rvalid=%b rdata=%h want 1 12345678", rvalid, rdata); end
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 32'h0, 4'hF);
    set_slv(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset();
    test_single_load();
    test_pipelined();
    test_mixed();
    test_simul_accept_ack();
    test_error();
    test_timeout();
    test_reset_mid();
    tick();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d pending responses want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
